// File: rtl/bus_phase_sequencer_pkg.sv
// Shared types and helpers for the two-phase latch-clock / bus-enable sequencer.
// Optional single-step support is selected with RV523_SINGLE_STEP_EN.
package rv523_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        GAP1 = 3'd2,
        PH2  = 3'd3,
        GAP2 = 3'd4
    } seq_state_t;

    function automatic int dwell_w(input int ph_cycles, input int gap_cycles);
        int longest;
        longest = (ph_cycles > gap_cycles) ? ph_cycles : gap_cycles;
        return $clog2(longest + 1);
    endfunction

    // Driver vectors wider than 32 bits are not supported.
    function automatic logic is_onehot(input logic [31:0] vec);
        return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/bus_phase_sequencer_if.sv
// Bundle of run/select requests and latch-clock / bus-enable outputs of the sequencer.
// RV523_SINGLE_STEP_EN adds the single-step request/acknowledge signals.
interface bus_phase_sequencer_if #(
    parameter int NUM_DRV = 4
);
    logic               RUN;
    logic [NUM_DRV-1:0] DRV_SEL;
    logic               PH1;
    logic               nPH1;
    logic               PH2;
    logic               nPH2;
    logic [NUM_DRV-1:0] BUS_EN;
    logic [NUM_DRV-1:0] nBUS_EN;
    logic               CYCLE_DONE;
    logic               SEL_ERR;
`ifdef RV523_SINGLE_STEP_EN
    logic               STEP_MODE;
    logic               STEP_REQ;
    logic               STEP_ACK;

    modport master (
        input  RUN, DRV_SEL, STEP_MODE, STEP_REQ,
        output PH1, nPH1, PH2, nPH2, BUS_EN, nBUS_EN, CYCLE_DONE, SEL_ERR, STEP_ACK
    );
    modport slave (
        output RUN, DRV_SEL, STEP_MODE, STEP_REQ,
        input  PH1, nPH1, PH2, nPH2, BUS_EN, nBUS_EN, CYCLE_DONE, SEL_ERR, STEP_ACK
    );
`else
    modport master (
        input  RUN, DRV_SEL,
        output PH1, nPH1, PH2, nPH2, BUS_EN, nBUS_EN, CYCLE_DONE, SEL_ERR
    );
    modport slave (
        output RUN, DRV_SEL,
        input  PH1, nPH1, PH2, nPH2, BUS_EN, nBUS_EN, CYCLE_DONE, SEL_ERR
    );
`endif
endinterface

// File: rtl/bus_phase_sequencer_dwell_counter.sv
// Loadable down-counter timing every phase and gap; saturates at zero.
// zero_nxt tells the owner whether the value about to be registered is zero.
module seq_dwell_counter #(
    parameter int W = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero,
    output logic         zero_nxt
);
    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;

    // Next count: load wins, otherwise decrement until zero.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load) begin
            cnt_nxt_s = load_val;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_nxt_s = cnt_r - W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r <= {W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt      = cnt_r;
    assign zero     = (cnt_r == {W{1'b0}});
    assign zero_nxt = (cnt_nxt_s == {W{1'b0}});

endmodule

// File: rtl/bus_phase_sequencer.sv
// Non-overlapping PH1/PH2 latch-clock and one-hot TINV enable sequencer.
// Define RV523_SINGLE_STEP_EN to add STEP_MODE/STEP_REQ/STEP_ACK single-step control.
module bus_phase_sequencer
    import rv523_seq_pkg::*;
#(
    parameter int PH_CYCLES  = 2,
    parameter int GAP_CYCLES = 1,
    parameter int NUM_DRV    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    bus_phase_sequencer_if.master bus
);
    localparam int DW = dwell_w(PH_CYCLES, GAP_CYCLES);
    localparam logic [DW-1:0] PH_LOAD  = DW'(PH_CYCLES - 1);
    localparam logic [DW-1:0] GAP_LOAD = DW'(GAP_CYCLES - 1);

    seq_state_t         state_r;
    seq_state_t         state_nxt_s;
    logic               load_s;
    logic [DW-1:0]      load_val_s;
    logic [DW-1:0]      cnt_s;
    logic               zero_s;
    logic               zero_nxt_s;
    logic [NUM_DRV-1:0] owner_r;
    logic [NUM_DRV-1:0] owner_nxt_s;
    logic [NUM_DRV-1:0] bus_en_nxt_s;
    logic               sample_s;
    logic               sel_ok_s;
    logic               start_s;
    logic               cont_s;
    logic               done_nxt_s;

    seq_dwell_counter #(.W(DW)) u_dwell (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load_s),
        .load_val (load_val_s),
        .cnt      (cnt_s),
        .zero     (zero_s),
        .zero_nxt (zero_nxt_s)
    );

`ifdef RV523_SINGLE_STEP_EN
    logic step_req_d_r;
    logic stepping_r;
    logic stepping_nxt_s;
    logic step_edge_s;

    assign step_edge_s = bus.STEP_REQ & ~step_req_d_r;
    // Step mode only ever starts from IDLE, so edges mid-cycle are simply ignored.
    assign start_s     = bus.STEP_MODE ? step_edge_s : bus.RUN;
    assign cont_s      = bus.STEP_MODE ? 1'b0 : bus.RUN;

    // A stepped cycle is tracked from its launch until GAP2 retires.
    always_comb begin
        stepping_nxt_s = stepping_r;
        if ((state_r == IDLE) && start_s && bus.STEP_MODE) begin
            stepping_nxt_s = 1'b1;
        end else if ((state_r == GAP2) && zero_s) begin
            stepping_nxt_s = 1'b0;
        end else begin
            stepping_nxt_s = stepping_r;
        end
    end
`else
    assign start_s = bus.RUN;
    assign cont_s  = bus.RUN;
`endif

    // Next state and dwell reload on every state entry.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        load_val_s  = {DW{1'b0}};
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nxt_s = PH1;
                    load_s      = 1'b1;
                    load_val_s  = PH_LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PH1: begin
                if (zero_s) begin
                    state_nxt_s = GAP1;
                    load_s      = 1'b1;
                    load_val_s  = GAP_LOAD;
                end else begin
                    state_nxt_s = PH1;
                end
            end
            GAP1: begin
                if (zero_s) begin
                    state_nxt_s = PH2;
                    load_s      = 1'b1;
                    load_val_s  = PH_LOAD;
                end else begin
                    state_nxt_s = GAP1;
                end
            end
            PH2: begin
                if (zero_s) begin
                    state_nxt_s = GAP2;
                    load_s      = 1'b1;
                    load_val_s  = GAP_LOAD;
                end else begin
                    state_nxt_s = PH2;
                end
            end
            GAP2: begin
                if (zero_s && cont_s) begin
                    state_nxt_s = PH1;
                    load_s      = 1'b1;
                    load_val_s  = PH_LOAD;
                end else if (zero_s) begin
                    state_nxt_s = IDLE;
                    load_s      = 1'b1;
                    load_val_s  = {DW{1'b0}};
                end else begin
                    state_nxt_s = GAP2;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                load_s      = 1'b1;
                load_val_s  = {DW{1'b0}};
            end
        endcase
    end

    assign sample_s   = (state_r == GAP1) && zero_s;
    assign sel_ok_s   = is_onehot(32'(bus.DRV_SEL));
    assign done_nxt_s = (state_nxt_s == GAP2) && zero_nxt_s;

    // Owner is latched once at the end of GAP1; a bad select parks it at no driver.
    always_comb begin
        owner_nxt_s  = owner_r;
        bus_en_nxt_s = {NUM_DRV{1'b0}};
        if (sample_s && sel_ok_s) begin
            owner_nxt_s = bus.DRV_SEL;
        end else if (sample_s) begin
            owner_nxt_s = {NUM_DRV{1'b0}};
        end else begin
            owner_nxt_s = owner_r;
        end
        if (state_nxt_s == PH2) begin
            bus_en_nxt_s = owner_nxt_s;
        end else begin
            bus_en_nxt_s = {NUM_DRV{1'b0}};
        end
    end

    // FSM state plus all outputs, registered from the next-state decode.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r        <= IDLE;
            owner_r        <= {NUM_DRV{1'b0}};
            bus.PH1        <= 1'b0;
            bus.nPH1       <= 1'b1;
            bus.PH2        <= 1'b0;
            bus.nPH2       <= 1'b1;
            bus.BUS_EN     <= {NUM_DRV{1'b0}};
            bus.nBUS_EN    <= {NUM_DRV{1'b1}};
            bus.CYCLE_DONE <= 1'b0;
            bus.SEL_ERR    <= 1'b0;
`ifdef RV523_SINGLE_STEP_EN
            // Capture the live level so a request held through reset is not an edge.
            step_req_d_r   <= bus.STEP_REQ;
            stepping_r     <= 1'b0;
            bus.STEP_ACK   <= 1'b0;
`endif
        end else begin
            state_r        <= state_nxt_s;
            owner_r        <= owner_nxt_s;
            bus.PH1        <= (state_nxt_s == PH1);
            bus.nPH1       <= (state_nxt_s != PH1);
            bus.PH2        <= (state_nxt_s == PH2);
            bus.nPH2       <= (state_nxt_s != PH2);
            bus.BUS_EN     <= bus_en_nxt_s;
            bus.nBUS_EN    <= ~bus_en_nxt_s;
            bus.CYCLE_DONE <= done_nxt_s;
            bus.SEL_ERR    <= sample_s && !sel_ok_s;
`ifdef RV523_SINGLE_STEP_EN
            step_req_d_r   <= bus.STEP_REQ;
            stepping_r     <= stepping_nxt_s;
            bus.STEP_ACK   <= done_nxt_s && stepping_r;
`endif
        end
    end

endmodule

// File: tb/tb_bus_phase_sequencer.sv
// Directed bench for bus_phase_sequencer: default-timing instance plus a PH=3/GAP=2 instance.
// Single-step scenario is compiled in when RV523_SINGLE_STEP_EN is defined.
module tb_bus_phase_sequencer;

    logic CLK = 1'b0;
    logic RST;
    logic RST_B;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    bus_phase_sequencer_if #(.NUM_DRV(4)) bus_a ();
    bus_phase_sequencer_if #(.NUM_DRV(4)) bus_b ();

    bus_phase_sequencer #(.PH_CYCLES(2), .GAP_CYCLES(1), .NUM_DRV(4)) dut_a (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_a.master)
    );

    bus_phase_sequencer #(.PH_CYCLES(3), .GAP_CYCLES(2), .NUM_DRV(4)) dut_b (
        .CLK (CLK),
        .RST (RST_B),
        .bus (bus_b.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic ph1, input logic ph2,
                         input logic [3:0] en, input logic cd, input logic se);
        logic       n1;
        logic       n2;
        logic [3:0] nen;
        n1  = ~ph1;
        n2  = ~ph2;
        nen = ~en;
        chk({tag, ".PH1"},        bus_a.PH1,        ph1);
        chk({tag, ".nPH1"},       bus_a.nPH1,       n1);
        chk({tag, ".PH2"},        bus_a.PH2,        ph2);
        chk({tag, ".nPH2"},       bus_a.nPH2,       n2);
        chk({tag, ".BUS_EN"},     bus_a.BUS_EN,     en);
        chk({tag, ".nBUS_EN"},    bus_a.nBUS_EN,    nen);
        chk({tag, ".CYCLE_DONE"}, bus_a.CYCLE_DONE, cd);
        chk({tag, ".SEL_ERR"},    bus_a.SEL_ERR,    se);
    endtask

    // One 6-clock cycle of dut_a: PH1 x2, gap, PH2 x2, gap (CYCLE_DONE on the last).
    task automatic run_cycle(input string tag, input logic [3:0] exp_en, input logic exp_err,
                             input logic [3:0] mid_sel, input logic mid_run);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_a($sformatf("%s_k%0d", tag, k), k < 2, (k == 3) || (k == 4),
                  ((k == 3) || (k == 4)) ? exp_en : 4'd0, k == 5, (k == 3) && exp_err);
            if (k == 0) bus_a.RUN = mid_run;
            if (k == 3) bus_a.DRV_SEL = mid_sel;
        end
    endtask

    initial begin
        int         zero_run;
        int         last_cd;
        logic       prev_ph1;
        logic       prev_ph2;
        logic [3:0] en_xor;

        RST           = 1'b1;
        RST_B         = 1'b1;
        bus_a.RUN     = 1'b0;
        bus_a.DRV_SEL = 4'd0;
        bus_b.RUN     = 1'b0;
        bus_b.DRV_SEL = 4'd0;
`ifdef RV523_SINGLE_STEP_EN
        bus_a.STEP_MODE = 1'b0;
        bus_a.STEP_REQ  = 1'b0;
        bus_b.STEP_MODE = 1'b0;
        bus_b.STEP_REQ  = 1'b0;
`endif

        // Reset held three clocks, then idle with RUN=0.
        repeat (3) tick();
        chk_a("reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_a($sformatf("idle_%0d", i), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        end

        // Continuous run with a one-hot owner.
        bus_a.DRV_SEL = 4'b0100;
        bus_a.RUN     = 1'b1;
        run_cycle("onehot0", 4'b0100, 1'b0, 4'b0100, 1'b1);
        run_cycle("onehot1", 4'b0100, 1'b0, 4'b0100, 1'b1);
        // Select change inside PH2 must not move the current owner.
        run_cycle("ph2_change", 4'b0100, 1'b0, 4'b0001, 1'b1);
        run_cycle("onehot2", 4'b0001, 1'b0, 4'b0001, 1'b1);

        // Illegal selects: no enable, SEL_ERR on PH2 entry.
        bus_a.DRV_SEL = 4'b0110;
        run_cycle("multi", 4'd0, 1'b1, 4'b0110, 1'b1);
        bus_a.DRV_SEL = 4'b0000;
        run_cycle("none", 4'd0, 1'b1, 4'b0000, 1'b1);

        // RUN dropped during PH1: cycle completes, then IDLE.
        bus_a.DRV_SEL = 4'b1000;
        run_cycle("run_drop", 4'b1000, 1'b0, 4'b1000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_a($sformatf("stopped_%0d", i), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        end

        // Reset in the first clock of PH2 clears everything on the next edge.
        bus_a.RUN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_a($sformatf("pre_rst_k%0d", k), k < 2, k == 3, (k == 3) ? 4'b1000 : 4'd0,
                  1'b0, 1'b0);
        end
        RST       = 1'b1;
        bus_a.RUN = 1'b0;
        tick();
        chk_a("rst_in_ph2", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        RST = 1'b0;
        tick();
        chk_a("after_rst", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // PH=3/GAP=2 instance: invariants under random RUN/DRV_SEL, period while RUN holds.
        zero_run  = 1000;
        last_cd   = -1;
        prev_ph1  = 1'b0;
        prev_ph2  = 1'b0;
        RST_B     = 1'b0;
        bus_b.RUN = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            bus_b.DRV_SEL = 4'($urandom_range(0, 15));
            if (c >= 100) bus_b.RUN = ($urandom_range(0, 3) != 0);
            tick();
            chk("b_ph_overlap", bus_b.PH1 & bus_b.PH2, 1'b0);
            chk("b_ph1_with_en", bus_b.PH1 & (|bus_b.BUS_EN), 1'b0);
            chk("b_en_outside_ph2", (|bus_b.BUS_EN) & ~bus_b.PH2, 1'b0);
            chk("b_en_onehot0", $countones(bus_b.BUS_EN) <= 1, 1'b1);
            chk("b_nph1_inverse", bus_b.PH1 ^ bus_b.nPH1, 1'b1);
            chk("b_nph2_inverse", bus_b.PH2 ^ bus_b.nPH2, 1'b1);
            en_xor = bus_b.BUS_EN ^ bus_b.nBUS_EN;
            chk("b_nbus_inverse", en_xor, 4'hF);
            if ((bus_b.PH1 && !prev_ph1) || (bus_b.PH2 && !prev_ph2)) begin
                chk("b_dead_time", zero_run >= 2, 1'b1);
            end
            if (!bus_b.PH1 && !bus_b.PH2) zero_run++;
            else zero_run = 0;
            if (bus_b.CYCLE_DONE) begin
                if ((c < 100) && (last_cd >= 0)) chk("b_period", c - last_cd, 10);
                last_cd = c;
            end
            prev_ph1 = bus_b.PH1;
            prev_ph2 = bus_b.PH2;
        end
        RST_B = 1'b1;

`ifdef RV523_SINGLE_STEP_EN
        // Single step with STEP_REQ held high: exactly one cycle, one STEP_ACK.
        begin
            int   ph1_rises;
            int   acks;
            int   dones;
            logic p1;
            ph1_rises       = 0;
            acks            = 0;
            dones           = 0;
            p1              = 1'b0;
            bus_a.STEP_MODE = 1'b1;
            bus_a.RUN       = 1'b1;
            bus_a.STEP_REQ  = 1'b1;
            bus_a.DRV_SEL   = 4'b0010;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (bus_a.PH1 && !p1) ph1_rises++;
                p1 = bus_a.PH1;
                if (bus_a.CYCLE_DONE) dones++;
                if (bus_a.STEP_ACK) begin
                    acks++;
                    chk("step_ack_with_done", bus_a.CYCLE_DONE, 1'b1);
                end
            end
            chk("step_ph1_rises", ph1_rises, 1);
            chk("step_acks", acks, 1);
            chk("step_dones", dones, 1);
            bus_a.STEP_REQ  = 1'b0;
            bus_a.STEP_MODE = 1'b0;
            bus_a.RUN       = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
